// File: rtl/fifo_drain_if.sv
// Handshake bundle between fifo_drain, its upstream fifo_sync and the downstream consumer.
// The master side is the drain engine; the slave side is the surrounding environment.
interface fifo_drain_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_drain.sv
// Drains a fifo_sync into a BUF_DEPTH-entry skid buffer; 2 cycles from fifo_rd_en to out_valid.
// Backpressure: reads are credit-limited so buffered plus in-flight words never exceed BUF_DEPTH.
module fifo_drain #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          cnt_clr,
    output logic [15:0]   word_count,
    output logic          busy,
    fifo_drain_if.master  io
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [PW+1:0] DEPTH_L  = (PW+2)'(BUF_DEPTH);
    localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_inflight;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_occ;
    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [15:0]      r_word_count;

    logic [PW+1:0]    w_credit;
    logic             w_rd_en;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;

    // Credits count both stored words and the word still on its way from fifo_sync.
    assign w_credit = {1'b0, r_occ} + {{(PW+1){1'b0}}, r_inflight};
    assign w_rd_en  = (r_state == RUN) && enable && !io.fifo_empty && !rst
                      && (w_credit < DEPTH_L);
    assign w_valid  = (r_occ != '0);
    assign w_push   = r_inflight;
    assign w_pop    = w_valid && io.out_ready;

    assign io.fifo_rd_en = w_rd_en;
    assign io.out_valid  = w_valid;
    assign io.out_data   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign busy          = r_busy;
    assign word_count    = r_word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        r_state <= RUN;
                    end else if (!r_inflight && !w_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The in-flight word is dropped on a reset edge rather than captured.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= io.fifo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_word_count <= 16'd0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain: a fifo_sync model feeds words, expected words are queued on
// issue, and a negedge monitor pops and compares every output transfer.
module tb_fifo_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cnt_clr;
    logic [15:0] word_count;
    logic        busy;

    fifo_drain_if #(.WIDTH(8)) bus ();

    fifo_drain #(.WIDTH(8), .BUF_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cnt_clr    (cnt_clr),
        .word_count (word_count),
        .busy       (busy),
        .io         (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Upstream fifo_sync model: registered data one cycle after the read enable.
    logic [7:0] up_mem [256];
    int         up_rd = 0;
    int         up_wr = 0;
    logic [7:0] up_dat = 8'h00;

    assign bus.fifo_empty = (up_rd == up_wr);
    assign bus.fifo_data  = up_dat;

    always @(posedge clk) begin
        if (rst) begin
            up_rd  <= up_wr;
            up_dat <= 8'h00;
        end else if (bus.fifo_rd_en) begin
            up_dat <= up_mem[up_rd % 256];
            up_rd  <= up_rd + 1;
        end
    end

    logic [7:0] sb [$];
    int cyc = 0;
    int reads_total = 0, xfers = 0, outst = 0, max_all = 0, bp_max = 0, rd_empty_viol = 0;
    int phase = 0, first_rd = -1, first_vld = -1, first_x = -1, last_x = -1, ph_xfers = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            outst = 0;
            chk("rd_en_during_rst", bus.fifo_rd_en, 0);
        end else begin
            int rd_now;
            int x_now;
            rd_now = bus.fifo_rd_en ? 1 : 0;
            x_now  = (bus.out_valid && bus.out_ready) ? 1 : 0;
            if (rd_now == 1) begin
                reads_total++;
                if (bus.fifo_empty) rd_empty_viol++;
            end
            if (prev_hold) chk("out_data_stable", bus.out_data, prev_data);
            if (x_now == 1) begin
                xfers++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected no transfer", bus.out_data);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    if (bus.out_data != e) begin
                        failures++;
                        $display("FAIL out_data_order: got %0h expected %0h", bus.out_data, e);
                    end
                end
            end
            if (phase == 1) begin
                if (rd_now == 1 && first_rd < 0) first_rd = cyc;
                if (bus.out_valid && first_vld < 0) first_vld = cyc;
                if (x_now == 1) begin
                    if (first_x < 0) first_x = cyc;
                    last_x = cyc;
                    ph_xfers++;
                end
            end
            outst = outst + rd_now - x_now;
            if (outst > max_all) max_all = outst;
            if (outst > bp_max) bp_max = outst;
        end
        prev_hold = !rst && bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        up_mem[up_wr % 256] = d;
        up_wr++;
        sb.push_back(d);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((sb.size() != 0 || bus.out_valid) && i < budget) begin
            tick(1);
            i++;
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid) begin
            failures++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
        end
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            tick(1);
            i++;
        end
        chk("idle_reached", busy, 0);
    endtask

    logic [7:0] stream_vec [16] = '{8'hFF, 8'h96, 8'h01, 8'h5C, 8'hE3, 8'h2A, 8'h7B, 8'h10,
                                    8'hC4, 8'h39, 8'h8E, 8'hD7, 8'h45, 8'hB2, 8'h6F, 8'hA8};
    logic [7:0] bp_vec [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    initial begin
        int rd_base;
        int x_base;
        int pushed;
        int guard;
        logic [7:0] d;

        rst = 1'b1;
        enable = 1'b0;
        cnt_clr = 1'b0;
        bus.out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_word_count", word_count, 0);
        chk("reset_rd_en", bus.fifo_rd_en, 0);

        // Streaming at full rate.
        foreach (stream_vec[i]) push_word(stream_vec[i]);
        phase = 1;
        enable = 1'b1;
        bus.out_ready = 1'b1;
        wait_drain(60);
        phase = 0;
        chk("stream_latency", first_vld - first_rd, 2);
        chk("stream_throughput", last_x - first_x, 15);
        chk("stream_xfers", ph_xfers, 16);
        chk("stream_word_count", word_count, 16);

        // Backpressure mid-stream.
        foreach (bp_vec[i]) push_word(bp_vec[i]);
        tick(3);
        bus.out_ready = 1'b0;
        bp_max = outst;
        tick(10);
        chk("bp_rd_stopped", bus.fifo_rd_en, 0);
        chk("bp_buffered", bp_max, 4);
        bus.out_ready = 1'b1;
        wait_drain(60);
        chk("bp_word_count", word_count, 28);

        // Flush with one read in flight and two words buffered.
        bus.out_ready = 1'b0;
        enable = 1'b0;
        wait_idle(20);
        for (int i = 0; i < 6; i++) push_word(8'hD0 + 8'(i));
        enable = 1'b1;
        rd_base = reads_total;
        tick(4);
        chk("flush_reads_before_fall", reads_total - rd_base, 3);
        enable = 1'b0;
        bus.out_ready = 1'b1;
        x_base = xfers;
        rd_base = reads_total;
        wait_idle(30);
        chk("flush_words_delivered", xfers - x_base, 3);
        tick(5);
        chk("flush_no_rd_after", reads_total - rd_base, 0);
        chk("flush_busy_low", busy, 0);
        enable = 1'b1;
        wait_drain(40);

        // Reset with three words buffered and one in flight.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'hE0 + 8'(i));
        tick(4);
        chk("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_busy", busy, 0);
        bus.out_ready = 1'b1;
        tick(8);
        push_word(8'h3A);
        push_word(8'h4B);
        push_word(8'h5C);
        wait_drain(30);
        chk("post_rst_word_count", word_count, 3);

        // Counter wrap.
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("cnt_clr_idle", word_count, 0);
        pushed = 0;
        guard = 0;
        while (pushed < 65535 && guard < 80000) begin
            if (up_wr - up_rd < 200) begin
                d = pushed[7:0] ^ 8'h3C;
                push_word(d);
                pushed++;
            end
            tick(1);
            guard++;
        end
        wait_drain(400);
        chk("count_65535", word_count, 16'hFFFF);
        push_word(8'h77);
        wait_drain(20);
        chk("count_wrap", word_count, 0);

        // Clear wins over a same-cycle transfer.
        bus.out_ready = 1'b0;
        push_word(8'h81);
        push_word(8'h82);
        tick(4);
        chk("clr_pre_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_priority", word_count, 0);
        wait_drain(20);
        chk("clr_then_count", word_count, 1);

        chk("rd_en_while_empty", rd_empty_viol, 0);
        chk("outstanding_le_depth", (max_all > 4) ? 1 : 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter WIDTH, default 8: data width, matching the fifo_sync data path.
REQ-002 Parameter BUF_DEPTH, default 4: entries in the output skid buffer, power of two, minimum 4.
REQ-003 Port clk, in, 1: the only clock; all logic on rising edge.
REQ-004 Port rst, in, 1: reset, synchronous, active-high.
REQ-005 Port enable, in, 1: 1 = drain the FIFO; 0 = stop issuing reads and flush.
REQ-006 Port fifo_empty, in, 1: empty flag from the upstream fifo_sync.
REQ-007 Port fifo_rd_en, out, 1: read enable to the upstream fifo_sync.
REQ-008 Port fifo_data, in, WIDTH: fifo_sync data_out, valid exactly 1 cycle after fifo_rd_en.
REQ-009 Port out_valid, out, 1: out_data holds a word.
REQ-010 Port out_ready, in, 1: downstream accepts; transfer when out_valid and out_ready are both 1 at a rising edge.
REQ-011 Port out_data, out, WIDTH: head word of the skid buffer.
REQ-012 Port cnt_clr, in, 1: synchronous clear of word_count.
REQ-013 Port word_count, out, 16: number of output transfers since reset or clear.
REQ-014 Port busy, out, 1: high in RUN and DRAIN states.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN; registered state, encoding free.
REQ-016 Transitions:
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->RUN when enable=1.
- DRAIN->IDLE when enable=0, no read in flight and buffer empty.
- All other cases hold state.
REQ-017 fifo_rd_en is combinational: 1 only when state=RUN, enable=1, fifo_empty=0, rst=0 and (buffer occupancy + in-flight reads) < BUF_DEPTH, using registered values.
REQ-018 fifo_rd_en never asserts while fifo_empty=1, regardless of any other condition.
REQ-019 A 1-bit in-flight flag registers fifo_rd_en. When set, fifo_data is written into the buffer tail at the end of that cycle.
REQ-020 Latency: fifo_rd_en high in cycle N -> word captured at end of N+1 -> out_valid high in cycle N+2 (with the buffer previously empty).
REQ-021 The buffer is a circular BUF_DEPTH-entry FIFO. Read and write pointers wrap modulo BUF_DEPTH; occupancy counter is log2(BUF_DEPTH)+1 bits.
REQ-022 Simultaneous capture and output transfer in one cycle leaves occupancy unchanged; both pointers advance.
REQ-023 With fifo_empty=0, enable=1 and out_ready held at 1, throughput is one word per cycle after the initial 2-cycle latency.
REQ-024 out_valid=1 whenever occupancy>0. out_data is the buffer head and stays stable while out_valid=1 and out_ready=0.
REQ-025 Words leave in exactly the order they were read from fifo_sync; no loss and no duplication.
REQ-026 The buffer never overflows. The credit rule in REQ-017 guarantees that every in-flight word has a free slot.
REQ-027 A read in flight when enable falls is still captured. DRAIN presents all buffered words before IDLE.
REQ-028 word_count increments by 1 per output transfer and wraps from 16'hFFFF to 16'h0000.
REQ-029 cnt_clr=1 forces word_count to 0 on the next edge and takes priority over a same-cycle transfer.
REQ-030 busy is decoded from registered state only.

Reset
REQ-031 When rst=1 at a rising edge:
- state becomes IDLE; out_valid 0, out_data 0, word_count 0, busy 0.
- occupancy, pointers and in-flight flag become 0.
REQ-032 fifo_rd_en is 0 during any cycle with rst=1.
REQ-033 Reset mid-operation discards all buffered and in-flight words. The in-flight word is not captured on the reset edge.

Verification
REQ-034 Stream: preload fifo_sync with 16 words 8'hFF, 8'h96, 8'h01 ... 8'hA8; enable=1, out_ready=1. -> Same 16 values appear in order, one per cycle. First out_valid comes 2 cycles after first fifo_rd_en. word_count=16; fifo_rd_en never high with fifo_empty=1.
REQ-035 Backpressure: out_ready=0 for 10 cycles mid-stream. -> At most 4 words buffered, fifo_rd_en stops, out_data held stable. After out_ready returns, order is intact and none are lost.
REQ-036 Flush: enable falls with 1 read in flight and 2 words buffered. -> All 3 words delivered, then busy=0 and state IDLE; no further fifo_rd_en.
REQ-037 Reset mid-stream with 3 words buffered. -> Next cycle out_valid=0, word_count=0, busy=0; no stale word appears after reset is released.
REQ-038 Counter: force 65535 transfers, then 1 more -> word_count=0. Assert cnt_clr in the same cycle as a transfer -> word_count=0.
